irq_ctrl: RTL and testbench

Memory-mapped interrupt controller that sits directly upstream of the core's interrupt port. It synchronises 32 external interrupt sources and latches them as level- or edge-triggered pending bits. It drives `irq_o` into the core's `irq_i` and retires edge-triggered pending bits on the core's `irq_ack_o`/`irq_id_o` acknowledge. Software configures it through a single-cycle OBI-style slave port that the bus decodes and selects.

---
 rtl/irq_ctrl.sv | 128 ++++++++++++
 tb/tb_irq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - 32-source level/edge interrupt controller with register slave port
module irq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] EDGE_RESET  = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] src_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] irq_o,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_id_i
);

    localparam logic [2:0] REG_PENDING = 3'd0;
    localparam logic [2:0] REG_ENABLE  = 3'd1;
    localparam logic [2:0] REG_EDGE    = 3'd2;
    localparam logic [2:0] REG_SET     = 3'd3;
    localparam logic [2:0] REG_RAW     = 3'd4;

    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] sync;
    logic [31:0] prev_q;
    logic [31:0] rise;
    logic [31:0] pend_q;
    logic [31:0] enable_q;
    logic [31:0] edge_q;
    logic [31:0] pending;
    logic [31:0] wmask;
    logic [31:0] w1c_bits;
    logic [31:0] set_bits;
    logic [31:0] ack_bits;
    logic [31:0] read_val;
    logic [2:0]  reg_sel;
    logic        wr_en;
    logic        rd_en;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        unused_addr;

    assign gnt_o       = 1'b1;
    assign reg_sel     = addr_i[4:2];
    assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};
    assign wr_en       = req_i & we_i;
    assign rd_en       = req_i & ~we_i;
    assign wmask       = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

    assign sync    = sync_q[SYNC_STAGES-1];
    assign rise    = sync & ~prev_q;
    assign pending = (edge_q & pend_q) | (~edge_q & sync);
    assign irq_o   = pending & enable_q;

    // Source synchroniser chain plus one-cycle history for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= src_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync;
        end
    end

    // Decode write side effects on pend_q; clears only touch edge-mode bits
    always_comb begin
        w1c_bits = '0;
        set_bits = '0;
        ack_bits = '0;
        if (wr_en && reg_sel == REG_PENDING) w1c_bits = wdata_i & wmask & edge_q;
        if (wr_en && reg_sel == REG_SET)     set_bits = wdata_i & wmask;
        if (irq_ack_i)                       ack_bits = (32'h1 << irq_id_i) & edge_q;
    end

    // Pending latch: any set source wins over a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~(w1c_bits | ack_bits)) | (rise & edge_q) | set_bits;
        end
    end

    // ENABLE and EDGE configuration registers with per-byte writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_q <= '0;
            edge_q   <= EDGE_RESET;
        end else begin
            if (wr_en && reg_sel == REG_ENABLE) enable_q <= (enable_q & ~wmask) | (wdata_i & wmask);
            if (wr_en && reg_sel == REG_EDGE)   edge_q   <= (edge_q & ~wmask) | (wdata_i & wmask);
        end
    end

    // Read mux sampled at the handshake edge
    always_comb begin
        read_val = '0;
        case (reg_sel)
            REG_PENDING: read_val = pending;
            REG_ENABLE:  read_val = enable_q;
            REG_EDGE:    read_val = edge_q;
            REG_RAW:     read_val = sync;
            default:     read_val = '0;
        endcase
    end

    // One-cycle response for every accepted request; writes return zero data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            rdata_q  <= rd_en ? read_val : 32'h0;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl against a per-bit behavioural model
module tb_irq_ctrl;

    localparam int          SS     = 2;
    localparam logic [31:0] EDGE_R = 32'h0000_F00F;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] src_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [31:0] irq_o;
    logic        irq_ack_i;
    logic [4:0]  irq_id_i;

    int errors = 0;
    int checks = 0;

    irq_ctrl #(.SYNC_STAGES(SS), .EDGE_RESET(EDGE_R)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .src_i(src_i), .req_i(req_i), .we_i(we_i),
        .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .irq_o(irq_o),
        .irq_ack_i(irq_ack_i), .irq_id_i(irq_id_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: src history, per-bit pending flags, config words, response
    logic [31:0] m_hist [SS];
    logic [31:0] m_prev, m_pend, m_en, m_edge, m_rdata;
    logic        m_rvalid;

    function automatic logic [31:0] m_sync();
        return m_hist[SS-1];
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        logic [31:0] s;
        s = m_sync();
        for (int i = 0; i < 32; i++) p[i] = m_edge[i] ? m_pend[i] : s[i];
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_hist[i] = '0;
        m_prev = '0; m_pend = '0; m_en = '0; m_edge = EDGE_R;
        m_rvalid = 1'b0; m_rdata = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock: model computes next state from applied inputs, then compare at negedge
    task automatic step();
        logic [31:0] s, nh0, np, ne, ned, rv, rd;
        logic        wr_ok, set_b, clr_b;
        int          reg_n;
        s = m_sync();
        reg_n = int'(addr_i[4:2]);
        case (reg_n)
            0: rv = m_pending();
            1: rv = m_en;
            2: rv = m_edge;
            4: rv = s;
            default: rv = 32'h0;
        endcase
        np = m_pend; ne = m_en; ned = m_edge;
        for (int i = 0; i < 32; i++) begin
            wr_ok = req_i && we_i && be_i[i/8];
            set_b = (m_edge[i] && s[i] && !m_prev[i]) || (wr_ok && reg_n == 3 && wdata_i[i]);
            clr_b = m_edge[i] && ((wr_ok && reg_n == 0 && wdata_i[i]) ||
                                  (irq_ack_i && int'(irq_id_i) == i));
            if (set_b) np[i] = 1'b1;
            else if (clr_b) np[i] = 1'b0;
            if (wr_ok && reg_n == 1) ne[i] = wdata_i[i];
            if (wr_ok && reg_n == 2) ned[i] = wdata_i[i];
        end
        rd = (req_i && !we_i) ? rv : 32'h0;
        nh0 = src_i;
        @(posedge clk_i);
        if (!rst_ni) begin
            model_reset();
        end else begin
            for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = nh0;
            m_prev = s; m_pend = np; m_en = ne; m_edge = ned;
            m_rvalid = req_i; m_rdata = rd;
        end
        @(negedge clk_i);
        check("irq_o", irq_o, m_pending() & m_en);
        check("rvalid_o", {31'h0, rvalid_o}, {31'h0, m_rvalid});
        check("rdata_o", rdata_o, m_rdata);
    endtask

    task automatic idle_bus();
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req_i = 1'b1; we_i = 1'b1; be_i = b; addr_i = a; wdata_i = d;
        step();
        idle_bus();
    endtask

    task automatic bus_read(input logic [31:0] a);
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = a; wdata_i = '0;
        step();
        idle_bus();
    endtask

    initial begin
        rst_ni = 1'b0; src_i = '0; irq_ack_i = 1'b0; irq_id_i = '0;
        idle_bus();
        model_reset();
        @(negedge clk_i);
        step();
        rst_ni = 1'b1;
        step();

        // Reset values
        bus_read(32'h8);  check("edge_reset", rdata_o, EDGE_R);
        bus_read(32'h4);  check("enable_reset", rdata_o, 32'h0);
        bus_read(32'h0);  check("pending_reset", rdata_o, 32'h0);

        // Level-mode source
        bus_write(32'h4, 32'h0000_0800, 4'hF);
        bus_write(32'h8, 32'h0, 4'hF);
        src_i = 32'h0000_0800;
        step(); check("level_lat1", irq_o, 32'h0);
        step(); check("level_rise", irq_o, 32'h0000_0800);
        bus_write(32'h0, 32'hFFFF_FFFF, 4'hF);
        check("level_w1c_ignored", irq_o, 32'h0000_0800);
        src_i = 32'h0;
        step(); step(); check("level_fall", irq_o, 32'h0);

        // Edge mode with acknowledge
        bus_write(32'h8, 32'h0001_0000, 4'hF);
        bus_write(32'h4, 32'h0001_0000, 4'hF);
        src_i = 32'h0001_0000;
        step();
        src_i = 32'h0;
        step(); check("edge_lat2", irq_o, 32'h0);
        step(); check("edge_rise", irq_o, 32'h0001_0000);
        step(); step(); check("edge_held", irq_o, 32'h0001_0000);
        irq_ack_i = 1'b1; irq_id_i = 5'd17;
        step(); irq_ack_i = 1'b0;
        check("ack_other_id", irq_o, 32'h0001_0000);
        irq_ack_i = 1'b1; irq_id_i = 5'd16;
        step(); irq_ack_i = 1'b0;
        check("ack_clear", irq_o, 32'h0);

        // Rise collides with W1C on bit 20
        bus_write(32'h8, 32'h0010_0000, 4'hF);
        bus_write(32'h4, 32'h0010_0000, 4'hF);
        src_i = 32'h0010_0000;
        step(); step();
        bus_write(32'h0, 32'h0010_0000, 4'hF);
        check("collision_set_wins", irq_o, 32'h0010_0000);
        src_i = 32'h0;
        bus_write(32'h0, 32'hFFFF_FFFF, 4'hF);
        check("collision_cleared", irq_o, 32'h0);

        // Byte enables on SET and W1C
        bus_write(32'h8, 32'hFFFF_FFFF, 4'hF);
        bus_write(32'hC, 32'hFFFF_FFFF, 4'b0100);
        bus_read(32'h0);  check("be_set", rdata_o, 32'h00FF_0000);
        bus_write(32'h0, 32'hFFFF_FFFF, 4'b0100);
        bus_read(32'h0);  check("be_w1c", rdata_o, 32'h0);

        // Back-to-back write then read
        req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h4; wdata_i = 32'hA5A5_A5A5;
        step(); check("b2b_rvalid1", {31'h0, rvalid_o}, 32'h1);
        we_i = 1'b0; wdata_i = '0;
        step(); check("b2b_rvalid2", {31'h0, rvalid_o}, 32'h1);
        check("b2b_rdata", rdata_o, 32'hA5A5_A5A5);
        idle_bus();
        step(); check("b2b_idle", {31'h0, rvalid_o}, 32'h0);
        bus_read(32'h1C); check("unmapped_read", rdata_o, 32'h0);

        // Asynchronous reset mid-transaction
        bus_write(32'hC, 32'h0000_00FF, 4'hF);
        check("pre_reset_irq", irq_o, 32'h0000_00A5);
        bus_read(32'h4);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_irq", irq_o, 32'h0);
        check("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        model_reset();
        src_i = 32'h0000_0001;
        @(negedge clk_i);
        rst_ni = 1'b1;
        bus_write(32'h4, 32'h0000_0001, 4'hF);
        step(); step(); step();
        check("release_high_src", irq_o, 32'h0000_0001);
        src_i = 32'h0;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            src_i     = (($urandom_range(0, 3) == 0) ? $urandom : src_i);
            req_i     = ($urandom_range(0, 1) == 1);
            we_i      = ($urandom_range(0, 1) == 1);
            be_i      = 4'($urandom);
            addr_i    = $urandom;
            wdata_i   = $urandom;
            irq_ack_i = ($urandom_range(0, 4) == 0);
            irq_id_i  = 5'($urandom);
            step();
        end
        idle_bus();
        irq_ack_i = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
